vector_store_unit: RTL
======================

Name: vector_store_unit

Overview:
- Write-side counterpart of the vector load path. Captures a 512-bit spike/weight/neuron-state vector on a start command and streams it to data memory as a burst of address/data write beats over a valid/ready channel.
- Transfer size is selected by the same funct encoding the register banks use: one register (32 b), four registers (128 b) or the full bank (512 b).
- Sits between the register-bank read ports and the memory write interface.

Parameters:
- VEC_W, 512, width of the captured vector (fixed; only 512 is supported).
- BEAT_W, 32, memory write data width per beat; legal values are 32, 64, 128.
- ADDR_W, 32, byte address width.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  command strobe, sampled on the rising edge of clk.
- funct  in  3  transfer size: 000 = 32 b, 001 = 128 b, 010 = 512 b; all other values are illegal.
- base_addr  in  ADDR_W  byte start address; the low log2(BEAT_W/8) bits are ignored.
- vec_in  in  VEC_W  source vector; bit 0 is the first bit stored.
- busy  out  1  high while state != IDLE.
- done  out  1  one-cycle pulse after the last beat is accepted.
- err  out  1  one-cycle pulse on an illegal funct.
- m_wvalid  out  1  write beat valid.
- m_wready  in  1  memory accepts the beat.
- m_waddr  out  ADDR_W  beat byte address, aligned to BEAT_W/8.
- m_wdata  out  BEAT_W  beat data.
- m_wstrb  out  BEAT_W/8  byte enables.
- m_wlast  out  1  marks the final beat of the burst.

Behaviour:
- Reset values: every output is 0 and state = IDLE. The capture register and beat counter are cleared.
- Reset mid-burst: applies immediately. m_wvalid drops asynchronously, the burst is abandoned, and no done pulse is issued.
- Sizing: bits = 32, 128 or 512 by funct; nbeats = max(1, bits/BEAT_W).
- Strobes: m_wstrb is all ones, except when bits < BEAT_W, where only the low bits/8 bytes are set.
- State machine: IDLE, SEND, DONE.
- IDLE:
  - start with a legal funct: capture vec_in, funct and the aligned base_addr; clear beat_cnt; go to SEND.
  - start with an illegal funct: err = 1 in the next cycle; no beats are issued; stay in IDLE.
  - start low: hold.
- SEND:
  - m_wvalid = 1.
  - m_wdata = captured[beat_cnt*BEAT_W +: BEAT_W].
  - m_waddr = aligned_base + beat_cnt*(BEAT_W/8), modulo 2^ADDR_W (wraps silently).
  - m_wlast = (beat_cnt == nbeats-1).
- Handshake rules:
  - A beat transfers on a cycle with m_wvalid & m_wready.
  - m_waddr, m_wdata, m_wstrb and m_wlast must stay stable while m_wvalid=1 and m_wready=0.
  - m_wvalid never deasserts before acceptance.
  - On a handshake that is not the last beat, beat_cnt increments.
  - On a handshake of the last beat, go to DONE.
- DONE: done = 1 and m_wvalid = 0 for exactly one cycle, then return to IDLE.
- Latency and throughput:
  - start is sampled at edge T; first m_wvalid at T+1.
  - With m_wready held high, one beat per cycle; done at T+1+nbeats.
  - busy is high from T+1 through the DONE cycle inclusive.
- Commands while busy: start is ignored; captured data and funct do not change.
- Back-to-back commands: a start in the DONE cycle is ignored. The next command is accepted from IDLE, so the minimum command spacing is nbeats+2 cycles.
- vec_in changes after capture have no effect on the burst in flight.

Test Plan:
- BEAT_W=32, funct=010, base=0x1000, vec_in word i = 0xA0000000+i, m_wready=1 -> 16 beats at 0x1000..0x103C, data 0xA0000000..0xA000000F, wstrb=0xF, wlast only on beat 15, done at T+17.
- BEAT_W=32, funct=001, base=0x2003 -> 4 beats at 0x2000, 0x2004, 0x2008, 0x200C (low bits ignored), then a one-cycle done pulse.
- BEAT_W=64, funct=000, vec_in[31:0]=0xDEADBEEF -> 1 beat, wdata[31:0]=0xDEADBEEF, wstrb=0x0F, wlast=1.
- funct=010, m_wready low for 3 cycles on beat 2, plus a start with a different vec_in during the stall -> beat 2 held stable, the second start ignored, and the burst completes with the original data.
- funct=011 -> err pulse for one cycle, m_wvalid never asserts, busy stays 0. Then base=0xFFFFFFF8, funct=001 -> addresses 0xFFFFFFF8, 0xFFFFFFFC, 0x0, 0x4.
- reset asserted mid-burst at beat 5 of 16 -> all outputs 0 immediately and no done pulse. The next start runs a full 16-beat burst from beat 0.

Source files
------------

// File: rtl/vector_store_unit.sv
// rtl/vector_store_unit.sv - captures a 512-bit vector on start and streams it to memory
// as a valid/ready burst of address/data write beats (32 b, 128 b or 512 b per command).
module vector_store_unit #(
  parameter int VEC_W  = 512,
  parameter int BEAT_W = 32,
  parameter int ADDR_W = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [2:0]          funct,
  input  logic [ADDR_W-1:0]   base_addr,
  input  logic [VEC_W-1:0]    vec_in,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic                m_wvalid,
  input  logic                m_wready,
  output logic [ADDR_W-1:0]   m_waddr,
  output logic [BEAT_W-1:0]   m_wdata,
  output logic [BEAT_W/8-1:0] m_wstrb,
  output logic                m_wlast
);

  localparam int BYTES = BEAT_W / 8;
  localparam int NBEAT = VEC_W / BEAT_W;
  localparam int CNT_W = $clog2(NBEAT);

  localparam logic [CNT_W-1:0] LAST32  = CNT_W'((32 >= BEAT_W) ? 32 / BEAT_W - 1 : 0);
  localparam logic [CNT_W-1:0] LAST128 = CNT_W'((128 >= BEAT_W) ? 128 / BEAT_W - 1 : 0);
  localparam logic [CNT_W-1:0] LAST512 = CNT_W'(NBEAT - 1);

  // Transfers narrower than a beat only enable their own low bytes.
  localparam logic [BYTES-1:0] STRB32  = (32 < BEAT_W) ? BYTES'(4'hF) : {BYTES{1'b1}};
  localparam logic [BYTES-1:0] STRB128 = (128 < BEAT_W) ? BYTES'(16'hFFFF) : {BYTES{1'b1}};

  typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;

  state_t                         state_q, state_d;
  logic [NBEAT-1:0][BEAT_W-1:0]   cap_q, cap_d;
  logic [2:0]                     funct_q, funct_d;
  logic [ADDR_W-1:0]              base_q, base_d;
  logic [CNT_W-1:0]               beat_cnt_q, beat_cnt_d;
  logic                           err_q, err_d;

  logic [CNT_W-1:0]               last_idx;
  logic [BYTES-1:0]               strb;
  logic                           legal;
  logic                           send;

  assign legal = (funct == 3'b000) || (funct == 3'b001) || (funct == 3'b010);

  always_comb begin
    last_idx = LAST512;
    strb     = {BYTES{1'b1}};
    case (funct_q)
      3'b000: begin
        last_idx = LAST32;
        strb     = STRB32;
      end
      3'b001: begin
        last_idx = LAST128;
        strb     = STRB128;
      end
      default: begin
        last_idx = LAST512;
        strb     = {BYTES{1'b1}};
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      cap_q      <= '0;
      funct_q    <= '0;
      base_q     <= '0;
      beat_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cap_q      <= cap_d;
      funct_q    <= funct_d;
      base_q     <= base_d;
      beat_cnt_q <= beat_cnt_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cap_d      = cap_q;
    funct_d    = funct_q;
    base_d     = base_q;
    beat_cnt_d = beat_cnt_q;
    err_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (legal) begin
            cap_d      = vec_in;
            funct_d    = funct;
            base_d     = base_addr & ~ADDR_W'(BYTES - 1);
            beat_cnt_d = '0;
            state_d    = SEND;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      SEND: begin
        if (m_wready) begin
          if (beat_cnt_q == last_idx) state_d = DONE;
          else beat_cnt_d = beat_cnt_q + 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Beat fields are forced to zero outside SEND so every output reads 0 when idle or in reset.
  assign send     = (state_q == SEND);
  assign m_wvalid = send;
  assign m_wdata  = send ? cap_q[beat_cnt_q] : '0;
  assign m_waddr  = send ? base_q + ADDR_W'(beat_cnt_q) * ADDR_W'(BYTES) : '0;
  assign m_wstrb  = send ? strb : '0;
  assign m_wlast  = send && (beat_cnt_q == last_idx);
  assign done     = (state_q == DONE);
  assign busy     = (state_q != IDLE);
  assign err      = err_q;

endmodule
